mem_word_ctrl: RTL and testbench

Load/store sequencer between the MIPS memory stage and the byte-wide data RAM. Accepts byte, halfword and word requests on a 32-bit interface and issues them as big-endian single-byte RAM accesses. Read data is assembled and extended, and completion is signalled with a one-cycle DONE pulse. Misaligned requests are rejected without touching the RAM.

---
 rtl/mem_word_ctrl_if.sv | 32 +++
 rtl/mem_word_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_word_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_word_ctrl_if.sv
// rtl/mem_word_ctrl_if.sv - request and byte-RAM bus bundle for the load/store sequencer
interface mem_word_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              REQ;
    logic              WE;
    logic [1:0]        SIZE;
    logic              SIGNED;
    logic [ADDR_W-1:0] ADDR;
    logic [31:0]       WDATA;
    logic [31:0]       RDATA;
    logic              BUSY;
    logic              DONE;
    logic              ERR;
    logic [ADDR_W-1:0] W_ADDR;
    logic [7:0]        W_DATA;
    logic [ADDR_W-1:0] DATA_ADDR;
    logic              RW_ENABLE;
    logic [7:0]        R_DATA;

    // Memory stage plus RAM side: drives requests and read bytes, observes results
    modport master (
        output REQ, WE, SIZE, SIGNED, ADDR, WDATA, R_DATA,
        input  RDATA, BUSY, DONE, ERR, W_ADDR, W_DATA, DATA_ADDR, RW_ENABLE
    );

    // The sequencer itself
    modport slave (
        input  REQ, WE, SIZE, SIGNED, ADDR, WDATA, R_DATA,
        output RDATA, BUSY, DONE, ERR, W_ADDR, W_DATA, DATA_ADDR, RW_ENABLE
    );
endinterface

// File: rtl/mem_word_ctrl.sv
// rtl/mem_word_ctrl.sv - byte/halfword/word load-store sequencer onto a byte-wide big-endian RAM
module mem_word_ctrl #(
    parameter int ADDR_W = 8
) (
    input logic            clk,
    input logic            rst,
    mem_word_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD,
        LWAIT,
        FIN
    } state_t;

    state_t            state;
    logic [2:0]        idx;       // next byte to issue; 1 after the first issue
    logic [2:0]        n_bytes;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [23:0]       asm_q;     // bytes received so far, most significant first
    logic              req_err;
    logic [2:0]        req_n;

    // Byte i of the used part of d, most significant used byte first
    function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [1:0] size,
                                             input logic [2:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (size)
            2'b00:   b = d[7:0];
            2'b01:   b = (i == 3'd0) ? d[15:8] : d[7:0];
            default: begin
                case (i[1:0])
                    2'd0:    b = d[31:24];
                    2'd1:    b = d[23:16];
                    2'd2:    b = d[15:8];
                    default: b = d[7:0];
                endcase
            end
        endcase
        return b;
    endfunction

    // Sign or zero extension of an assembled load value
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic sgn);
        logic [31:0] r;
        case (size)
            2'b00:   r = {{24{sgn & raw[7]}}, raw[7:0]};
            2'b01:   r = {{16{sgn & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Request decode: alignment/size check and byte count, used only at acceptance
    always_comb begin
        req_err = (bus.SIZE == 2'b11)
                | ((bus.SIZE == 2'b01) & bus.ADDR[0])
                | ((bus.SIZE == 2'b10) & (bus.ADDR[1:0] != 2'b00));
        case (bus.SIZE)
            2'b00:   req_n = 3'd1;
            2'b01:   req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
    end

    // Sequencer: state, latched request and every registered output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            n_bytes       <= '0;
            base          <= '0;
            wdata_q       <= '0;
            size_q        <= '0;
            signed_q      <= 1'b0;
            asm_q         <= '0;
            bus.RDATA     <= '0;
            bus.BUSY      <= 1'b0;
            bus.DONE      <= 1'b0;
            bus.ERR       <= 1'b0;
            bus.W_ADDR    <= '0;
            bus.W_DATA    <= '0;
            bus.DATA_ADDR <= '0;
            bus.RW_ENABLE <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.REQ) begin
                        base     <= bus.ADDR;
                        wdata_q  <= bus.WDATA;
                        size_q   <= bus.SIZE;
                        signed_q <= bus.SIGNED;
                        n_bytes  <= req_n;
                        asm_q    <= '0;
                        bus.BUSY <= 1'b1;
                        if (req_err) begin
                            // Rejected before any RAM strobe is raised
                            state    <= FIN;
                            idx      <= '0;
                            bus.DONE <= 1'b1;
                            bus.ERR  <= 1'b1;
                        end else if (bus.WE) begin
                            state         <= STORE;
                            idx           <= 3'd1;
                            bus.RW_ENABLE <= 1'b1;
                            bus.W_ADDR    <= bus.ADDR;
                            bus.W_DATA    <= pick_byte(bus.WDATA, bus.SIZE, 3'd0);
                        end else begin
                            state         <= LOAD;
                            idx           <= 3'd1;
                            bus.DATA_ADDR <= bus.ADDR;
                        end
                    end
                end
                STORE: begin
                    if (idx == n_bytes) begin
                        state         <= FIN;
                        bus.RW_ENABLE <= 1'b0;
                        bus.W_ADDR    <= '0;
                        bus.W_DATA    <= '0;
                        bus.DONE      <= 1'b1;
                    end else begin
                        idx        <= idx + 3'd1;
                        bus.W_ADDR <= base + ADDR_W'(idx);
                        bus.W_DATA <= pick_byte(wdata_q, size_q, idx);
                    end
                end
                LOAD: begin
                    // The RAM answers one cycle late, so the first edge has no byte yet
                    if (idx != 3'd1) begin
                        asm_q <= {asm_q[15:0], bus.R_DATA};
                    end
                    if (idx == n_bytes) begin
                        state         <= LWAIT;
                        bus.DATA_ADDR <= '0;
                    end else begin
                        idx           <= idx + 3'd1;
                        bus.DATA_ADDR <= base + ADDR_W'(idx);
                    end
                end
                LWAIT: begin
                    state     <= FIN;
                    bus.RDATA <= extend({asm_q, bus.R_DATA}, size_q, signed_q);
                    bus.DONE  <= 1'b1;
                end
                FIN: begin
                    state    <= IDLE;
                    bus.DONE <= 1'b0;
                    bus.ERR  <= 1'b0;
                    bus.BUSY <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_word_ctrl.sv
// tb/tb_mem_word_ctrl.sv - scoreboard bench for mem_word_ctrl with a registered byte RAM model
module tb_mem_word_ctrl;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          done_cyc;
        int          strobes;
    } exp_t;

    logic       clk;
    logic       rst;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         strobes = 0;
    exp_t       sb[$];
    logic [7:0] ram [256] = '{default: 8'h00};

    mem_word_ctrl_if #(.ADDR_W(8)) bus ();

    mem_word_ctrl #(.ADDR_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM with registered read
    always @(posedge clk) begin
        if (bus.RW_ENABLE) ram[bus.W_ADDR] <= bus.W_DATA;
        bus.R_DATA <= ram[bus.DATA_ADDR];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {4'h0, bus.RDATA, bus.BUSY, bus.DONE, bus.ERR, bus.RW_ENABLE,
                bus.W_ADDR, bus.W_DATA, bus.DATA_ADDR};
    endfunction

    // Monitor: pops one expectation per DONE pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
                strobes = 0;
            end else begin
                if (bus.RW_ENABLE) strobes++;
                if (bus.DONE) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: DONE at cycle %0d with nothing pending", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                        check("err", 64'(bus.ERR), 64'(e.err));
                        check("rdata", 64'(bus.RDATA), 64'(e.rdata));
                        check("strobes", 64'(strobes), 64'(e.strobes));
                    end
                    strobes = 0;
                end
            end
        end
    end

    // Issue one request; cyc_no is the spec cycle number of DONE counted from acceptance
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [7:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input int cyc_no, input int exp_strobes);
        exp_t e;
        int   t;
        @(negedge clk);
        bus.REQ    = 1'b1;
        bus.WE     = we;
        bus.SIZE   = size;
        bus.SIGNED = sgn;
        bus.ADDR   = addr;
        bus.WDATA  = wdata;
        e.err      = exp_err;
        e.rdata    = exp_rdata;
        e.done_cyc = cyc + cyc_no;
        e.strobes  = exp_strobes;
        sb.push_back(e);
        @(negedge clk);
        bus.REQ = 1'b0;
        t = 0;
        while (!bus.DONE && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no DONE within 20 cycles, addr %0h", addr);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        bus.REQ    = 1'b0;
        bus.WE     = 1'b0;
        bus.SIZE   = 2'b00;
        bus.SIGNED = 1'b0;
        bus.ADDR   = '0;
        bus.WDATA  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 64'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Word store then load
        issue(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0, 5, 4);
        check("ram_10", 64'(ram[8'h10]), 64'hDE);
        check("ram_11", 64'(ram[8'h11]), 64'hAD);
        check("ram_12", 64'(ram[8'h12]), 64'hBE);
        check("ram_13", 64'(ram[8'h13]), 64'hEF);
        issue(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF, 6, 0);

        // Byte load extension
        issue(1'b1, 2'b00, 1'b0, 8'h21, 32'hFFFFFF80, 1'b0, 32'hDEADBEEF, 2, 1);
        check("ram_21", 64'(ram[8'h21]), 64'h80);
        issue(1'b0, 2'b00, 1'b1, 8'h21, 32'h0, 1'b0, 32'hFFFFFF80, 3, 0);
        issue(1'b0, 2'b00, 1'b0, 8'h21, 32'h0, 1'b0, 32'h00000080, 3, 0);

        // Halfword store and signed load
        issue(1'b1, 2'b01, 1'b0, 8'h40, 32'h1234ABCD, 1'b0, 32'h00000080, 3, 2);
        check("ram_40", 64'(ram[8'h40]), 64'hAB);
        check("ram_41", 64'(ram[8'h41]), 64'hCD);
        check("ram_42", 64'(ram[8'h42]), 64'h00);
        issue(1'b0, 2'b01, 1'b1, 8'h40, 32'h0, 1'b0, 32'hFFFFABCD, 4, 0);

        // Misaligned and illegal requests
        issue(1'b1, 2'b10, 1'b0, 8'h42, 32'h55555555, 1'b1, 32'hFFFFABCD, 1, 0);
        issue(1'b0, 2'b01, 1'b0, 8'h43, 32'h0, 1'b1, 32'hFFFFABCD, 1, 0);
        issue(1'b1, 2'b11, 1'b0, 8'h00, 32'h77777777, 1'b1, 32'hFFFFABCD, 1, 0);
        check("ram_00_after_err", 64'(ram[8'h00]), 64'h00);

        // Top-of-memory word store, then zero-extended halfword load from 0xFE
        issue(1'b1, 2'b10, 1'b0, 8'hFC, 32'h01020304, 1'b0, 32'hFFFFABCD, 5, 4);
        check("ram_fc", 64'(ram[8'hFC]), 64'h01);
        check("ram_fd", 64'(ram[8'hFD]), 64'h02);
        check("ram_fe", 64'(ram[8'hFE]), 64'h03);
        check("ram_ff", 64'(ram[8'hFF]), 64'h04);
        check("ram_00_no_wrap", 64'(ram[8'h00]), 64'h00);
        issue(1'b0, 2'b01, 1'b0, 8'hFE, 32'h0, 1'b0, 32'h00000304, 4, 0);

        // REQ held through BUSY with changed operands must be ignored
        begin
            exp_t e;
            @(negedge clk);
            bus.REQ    = 1'b1;
            bus.WE     = 1'b1;
            bus.SIZE   = 2'b00;
            bus.SIGNED = 1'b0;
            bus.ADDR   = 8'h50;
            bus.WDATA  = 32'h0000005A;
            e.err      = 1'b0;
            e.rdata    = 32'h00000304;
            e.done_cyc = cyc + 2;
            e.strobes  = 1;
            sb.push_back(e);
            @(negedge clk);
            bus.ADDR  = 8'h51;
            bus.WDATA = 32'h00000066;
            repeat (2) @(negedge clk);
            bus.REQ = 1'b0;
            repeat (6) @(negedge clk);
            check("ram_50", 64'(ram[8'h50]), 64'h5A);
            check("ram_51_ignored", 64'(ram[8'h51]), 64'h00);
            check("busy_after_ignored", 64'(bus.BUSY), 64'h0);
        end

        // Reset in cycle 2 of a word store
        @(negedge clk);
        bus.REQ   = 1'b1;
        bus.WE    = 1'b1;
        bus.SIZE  = 2'b10;
        bus.ADDR  = 8'h80;
        bus.WDATA = 32'h11223344;
        @(negedge clk);
        bus.REQ = 1'b0;
        check("midstore_c1_addr", {bus.RW_ENABLE, bus.BUSY, bus.W_ADDR, bus.W_DATA}, {2'b11, 8'h80, 8'h11});
        @(negedge clk);
        check("midstore_c2_addr", {bus.RW_ENABLE, bus.BUSY, bus.W_ADDR, bus.W_DATA}, {2'b11, 8'h81, 8'h22});
        rst = 1'b0;
        #1;
        check("midstore_reset_outputs", outs(), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ram_80_written", 64'(ram[8'h80]), 64'h11);
        check("ram_81_untouched", 64'(ram[8'h81]), 64'h00);
        check("ram_82_untouched", 64'(ram[8'h82]), 64'h00);
        issue(1'b0, 2'b00, 1'b0, 8'h80, 32'h0, 1'b0, 32'h00000011, 3, 0);

        repeat (3) @(negedge clk);
        check("pending_expectations", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
